// File: rtl/round_referee.sv
// Round controller for the two-player reaction game: arm delay, GO window, judging, scoring.
// Define REACT_TIME_EN to build the winner reaction-time capture on react_cyc.
module round_referee #(
    parameter int unsigned ROUNDS      = 5,
    parameter int unsigned ARM_MIN_CYC = 25_000_000,
    parameter int unsigned ARM_BITS    = 24,
    parameter int unsigned GO_TMO_CYC  = 100_000_000,
    parameter logic [23:0] LFSR_SEED   = 24'hACE1B5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_start,
    input  logic        btn1,
    input  logic        btn2,
    input  logic        wait_done,
    output logic        is_final,
    output logic        go_led,
    output logic [2:0]  round_idx,
    output logic [2:0]  score1,
    output logic [2:0]  score2,
    output logic [1:0]  round_result,
    output logic [1:0]  foul,
    output logic        game_over,
    output logic [31:0] react_cyc
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_GO, S_HOLD, S_DONE} state_t;

    localparam logic [1:0]  RES_NONE   = 2'b00;
    localparam logic [1:0]  RES_P1     = 2'b01;
    localparam logic [1:0]  RES_P2     = 2'b10;
    localparam logic [1:0]  RES_DRAW   = 2'b11;
    localparam logic [2:0]  LAST_ROUND = 3'(ROUNDS - 1);
    localparam logic [31:0] ARM_MIN    = 32'(ARM_MIN_CYC);
    localparam logic [31:0] TMO_LAST   = 32'(GO_TMO_CYC - 1);

    state_t      state, state_nxt;
    logic [23:0] lfsr;
    logic [1:0]  sync_a, sync_b, sync_c;
    logic [1:0]  press;
    logic [31:0] arm_cnt, arm_cnt_nxt;
    logic [31:0] go_cnt, go_cnt_nxt;
    logic [31:0] arm_load;
    logic        seen_low, seen_low_nxt;
    logic [2:0]  round_nxt, score1_nxt, score2_nxt;
    logic [1:0]  result_nxt, foul_nxt;
    logic        arm_entry;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
        end
    end

    // bit0 follows btn1, bit1 follows btn2; press is the rising edge after two sync flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
            sync_c <= 2'b00;
        end else begin
            sync_a <= {btn2, btn1};
            sync_b <= sync_a;
            sync_c <= sync_b;
        end
    end

    assign press    = sync_b & ~sync_c;
    assign arm_load = ARM_MIN + 32'(lfsr[ARM_BITS-1:0]);

    always_comb begin
        state_nxt    = state;
        arm_cnt_nxt  = arm_cnt;
        go_cnt_nxt   = go_cnt;
        seen_low_nxt = 1'b0;
        round_nxt    = round_idx;
        score1_nxt   = score1;
        score2_nxt   = score2;
        result_nxt   = round_result;
        foul_nxt     = foul;
        arm_entry    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (game_start) begin
                    score1_nxt = 3'd0;
                    score2_nxt = 3'd0;
                    round_nxt  = 3'd0;
                    arm_entry  = 1'b1;
                end
            end
            S_ARM: begin
                if (press == 2'b11) begin
                    foul_nxt  = 2'b11;
                    state_nxt = S_HOLD;
                end else if (press[0]) begin
                    foul_nxt   = 2'b01;
                    score2_nxt = sat_inc(score2);
                    state_nxt  = S_HOLD;
                end else if (press[1]) begin
                    foul_nxt   = 2'b10;
                    score1_nxt = sat_inc(score1);
                    state_nxt  = S_HOLD;
                end else if (arm_cnt == 32'd0) begin
                    go_cnt_nxt = 32'd0;
                    state_nxt  = S_GO;
                end else begin
                    arm_cnt_nxt = arm_cnt - 32'd1;
                end
            end
            S_GO: begin
                // a press judged on the timeout cycle still counts
                if (press == 2'b11) begin
                    result_nxt = RES_DRAW;
                    state_nxt  = S_HOLD;
                end else if (press[0]) begin
                    result_nxt = RES_P1;
                    score1_nxt = sat_inc(score1);
                    state_nxt  = S_HOLD;
                end else if (press[1]) begin
                    result_nxt = RES_P2;
                    score2_nxt = sat_inc(score2);
                    state_nxt  = S_HOLD;
                end else if (go_cnt == TMO_LAST) begin
                    result_nxt = RES_DRAW;
                    state_nxt  = S_HOLD;
                end else begin
                    go_cnt_nxt = go_cnt + 32'd1;
                end
            end
            S_HOLD: begin
                // leave only after the delay stage has gone busy and come back idle
                seen_low_nxt = seen_low | ~wait_done;
                if (seen_low && wait_done) begin
                    if (round_idx == LAST_ROUND) begin
                        state_nxt = S_DONE;
                    end else begin
                        round_nxt = round_idx + 3'd1;
                        arm_entry = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (arm_entry) begin
            state_nxt   = S_ARM;
            arm_cnt_nxt = arm_load;
            result_nxt  = RES_NONE;
            foul_nxt    = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            arm_cnt      <= 32'd0;
            go_cnt       <= 32'd0;
            seen_low     <= 1'b0;
            round_idx    <= 3'd0;
            score1       <= 3'd0;
            score2       <= 3'd0;
            round_result <= RES_NONE;
            foul         <= 2'b00;
            is_final     <= 1'b0;
            go_led       <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_nxt;
            arm_cnt      <= arm_cnt_nxt;
            go_cnt       <= go_cnt_nxt;
            seen_low     <= seen_low_nxt;
            round_idx    <= round_nxt;
            score1       <= score1_nxt;
            score2       <= score2_nxt;
            round_result <= result_nxt;
            foul         <= foul_nxt;
            is_final     <= (round_nxt == LAST_ROUND) &&
                            (state_nxt == S_ARM || state_nxt == S_GO || state_nxt == S_HOLD);
            go_led       <= (state_nxt == S_GO);
            game_over    <= (state_nxt == S_DONE);
        end
    end

`ifdef REACT_TIME_EN
    // the GO timeout counter doubles as the reaction counter
    logic judge_win, judge_miss;

    always_comb begin
        judge_win  = 1'b0;
        judge_miss = 1'b0;
        if (state == S_ARM) begin
            judge_miss = |press;
        end else if (state == S_GO) begin
            if (press == 2'b01 || press == 2'b10) begin
                judge_win = 1'b1;
            end else if (press == 2'b11 || go_cnt == TMO_LAST) begin
                judge_miss = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            react_cyc <= 32'd0;
        end else if (judge_win) begin
            react_cyc <= go_cnt;
        end else if (judge_miss) begin
            react_cyc <= 32'hFFFF_FFFF;
        end
    end
`else
    assign react_cyc = 32'd0;
`endif

endmodule
